sdr_bit_engine: RTL



---
 rtl/sdr_pkg.sv | 25 ++
 rtl/sdr_bit_engine_if.sv | 27 ++
 rtl/sdr_bit_engine.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/sdr_pkg.sv
// Shared SDR definitions: transfer mode encodings, bit-engine state enum and the
// odd-parity helper used to generate and check the I3C T-bit.
package sdr_pkg;

   localparam int unsigned SDR_MODE_W   = 2;
   localparam int unsigned SDR_PARITY_W = 32;

   localparam logic [SDR_MODE_W-1:0] SDR_MODE_TX  = 2'b00;
   localparam logic [SDR_MODE_W-1:0] SDR_MODE_RX  = 2'b01;
   localparam logic [SDR_MODE_W-1:0] SDR_MODE_ACK = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_NEG,
      ST_SHIFT,
      ST_TBIT,
      ST_ACK
   } sdr_bit_state_e;

   // Zero-extension does not change the XOR, so any width up to SDR_PARITY_W fits.
   function automatic logic sdr_odd_parity(input logic [SDR_PARITY_W-1:0] v);
      return ~^v;
   endfunction

endpackage

// File: rtl/sdr_bit_engine_if.sv
// Command/status bundle between the SDR controller FSM (master) and the bit
// engine (slave).
interface sdr_bit_engine_if
   import sdr_pkg::*;
#(
   parameter int unsigned DATA_W = 8
);
   logic                  i_start;
   logic [SDR_MODE_W-1:0] i_mode;
   logic [DATA_W-1:0]     i_tx_data;
   logic                  i_abort;
   logic [DATA_W-1:0]     o_rx_data;
   logic                  o_busy;
   logic                  o_done;
   logic                  o_parity_err;
   logic                  o_nack;

   modport master (
      output i_start, i_mode, i_tx_data, i_abort,
      input  o_rx_data, o_busy, o_done, o_parity_err, o_nack
   );

   modport slave (
      input  i_start, i_mode, i_tx_data, i_abort,
      output o_rx_data, o_busy, o_done, o_parity_err, o_nack
   );
endinterface

// File: rtl/sdr_bit_engine.sv
// SDR bit serializer/deserializer driven by SCL edge strobes: TX/RX byte plus
// T-bit, and ACK sampling. Optional macro: SDR_BIT_ENGINE_PARITY_CHECK_EN.
module sdr_bit_engine
   import sdr_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  logic                    i_sdr_ctrl_clk,
   input  logic                    i_sdr_ctrl_rst_n,
   input  logic                    i_scl_pos_edge,
   input  logic                    i_scl_neg_edge,
   input  logic                    i_sda,
   output logic                    o_sda,
   output logic                    o_sda_oe,
   sdr_bit_engine_if.slave         cmd_if
);

   localparam int unsigned CNT_W = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   sdr_bit_state_e        r_state;
   logic [SDR_MODE_W-1:0] r_mode;
   logic [DATA_W-1:0]     r_tx_data;
   logic [DATA_W-1:0]     r_shift;
   logic [CNT_W-1:0]      r_bit_cnt;
   logic                  r_sda;
   logic                  r_sda_oe;
   logic [DATA_W-1:0]     r_rx_data;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_nack;
   logic                  w_accept;
   logic                  w_tx;
   logic                  w_rx;

   // The done cycle itself refuses a start so the controller sees status first.
   assign w_accept = cmd_if.i_start && !r_busy && !r_done;
   assign w_tx     = (r_mode == SDR_MODE_TX);
   assign w_rx     = (r_mode == SDR_MODE_RX);

   always_ff @(posedge i_sdr_ctrl_clk or negedge i_sdr_ctrl_rst_n) begin
      if (!i_sdr_ctrl_rst_n) begin
         r_state   <= ST_IDLE;
         r_mode    <= SDR_MODE_TX;
         r_tx_data <= '0;
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_sda     <= 1'b1;
         r_sda_oe  <= 1'b0;
         r_rx_data <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_nack    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (cmd_if.i_abort) begin
            r_state  <= ST_IDLE;
            r_sda_oe <= 1'b0;
            r_busy   <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_accept) begin
                     r_mode    <= (cmd_if.i_mode == SDR_MODE_TX || cmd_if.i_mode == SDR_MODE_RX)
                                  ? cmd_if.i_mode : SDR_MODE_ACK;
                     r_tx_data <= cmd_if.i_tx_data;
                     r_shift   <= cmd_if.i_tx_data;
                     r_bit_cnt <= '0;
                     r_nack    <= 1'b0;
                     r_busy    <= 1'b1;
                     r_state   <= ST_WAIT_NEG;
                  end else if (i_scl_neg_edge) begin
                     r_sda_oe <= 1'b0;
                  end
               end
               ST_WAIT_NEG: begin
                  if (i_scl_neg_edge) begin
                     if (w_tx) begin
                        r_sda    <= r_shift[DATA_W-1];
                        r_shift  <= {r_shift[DATA_W-2:0], 1'b0};
                        r_sda_oe <= 1'b1;
                        r_state  <= ST_SHIFT;
                     end else begin
                        r_sda_oe <= 1'b0;
                        r_state  <= w_rx ? ST_SHIFT : ST_ACK;
                     end
                  end
               end
               ST_SHIFT: begin
                  if (i_scl_pos_edge) begin
                     if (w_rx)
                        r_shift <= {r_shift[DATA_W-2:0], i_sda};
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                     if (r_bit_cnt == CNT_LAST)
                        r_state <= ST_TBIT;
                  end else if (i_scl_neg_edge && w_tx) begin
                     r_sda   <= r_shift[DATA_W-1];
                     r_shift <= {r_shift[DATA_W-2:0], 1'b0};
                  end
               end
               ST_TBIT: begin
                  if (i_scl_neg_edge && w_tx) begin
                     r_sda <= sdr_odd_parity(SDR_PARITY_W'(r_tx_data));
                  end else if (i_scl_pos_edge) begin
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                     if (w_rx)
                        r_rx_data <= r_shift;
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= ST_IDLE;
                  end
               end
               ST_ACK: begin
                  if (i_scl_pos_edge) begin
                     r_nack  <= i_sda;
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= ST_IDLE;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

`ifdef SDR_BIT_ENGINE_PARITY_CHECK_EN
   logic r_parity_err;

   always_ff @(posedge i_sdr_ctrl_clk or negedge i_sdr_ctrl_rst_n) begin
      if (!i_sdr_ctrl_rst_n) begin
         r_parity_err <= 1'b0;
      end else if (cmd_if.i_abort) begin
         r_parity_err <= r_parity_err;
      end else if (r_state == ST_IDLE && w_accept) begin
         r_parity_err <= 1'b0;
      end else if (r_state == ST_TBIT && i_scl_pos_edge && w_rx) begin
         r_parity_err <= (i_sda != sdr_odd_parity(SDR_PARITY_W'(r_shift)));
      end
   end

   assign cmd_if.o_parity_err = r_parity_err;
`else
   assign cmd_if.o_parity_err = 1'b0;
`endif

   assign o_sda            = r_sda;
   assign o_sda_oe         = r_sda_oe;
   assign cmd_if.o_rx_data = r_rx_data;
   assign cmd_if.o_busy    = r_busy;
   assign cmd_if.o_done    = r_done;
   assign cmd_if.o_nack    = r_nack;

   a_no_dual_edge: assert property (
      @(posedge i_sdr_ctrl_clk) disable iff (!i_sdr_ctrl_rst_n)
      !(i_scl_pos_edge && i_scl_neg_edge));

endmodule
